// File: rtl/seq_arbiter_pkg.sv
// Shared types and helpers for the round-robin sequence arbiter.
package seq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SEQ_SEED_DEFAULT = 4'b0101;

    // A requested length of zero stands for a full 2^width burst.
    function automatic int unsigned burst_count(input int unsigned len,
                                                input int unsigned width);
        return (len == 0) ? (32'd1 << width) : len;
    endfunction

endpackage

// File: rtl/seq_pos_counter.sv
// Per-requester saved sequence position: up counter with synchronous clear and enable.
module seq_pos_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    output logic [WIDTH-1:0] Pos
);

    logic [WIDTH-1:0] pos_q, pos_d;

    // Clear takes priority over the increment.
    always_comb begin
        pos_d = pos_q;
        if (Clr) begin
            pos_d = '0;
        end else if (En) begin
            pos_d = pos_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign Pos = pos_q;

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin time-sharing of one XOR-pattern sequence generator between two
// requesters, each resuming from its own saved position on its next grant.
module seq_arbiter
    import seq_arbiter_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEQ_SEED_DEFAULT)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       Req,
    input  logic [WIDTH-1:0] Len0,
    input  logic [WIDTH-1:0] Len1,
    input  logic [1:0]       Clr,
    output logic [1:0]       Grant,
    output logic             Valid,
    output logic [WIDTH-1:0] Number,
    output logic [1:0]       Done,
    output logic             Busy
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [1:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   rem_q, rem_d;

    logic             win;
    logic [WIDTH-1:0] pos0, pos1, pos_w;
    logic [1:0]       pos_en;

    assign pos_en[0] = (state_q == ST_RUN) && !owner_q;
    assign pos_en[1] = (state_q == ST_RUN) &&  owner_q;
    assign pos_w     = owner_q ? pos1 : pos0;

    seq_pos_counter #(.WIDTH(WIDTH)) u_pos0 (
        .CLK   (CLK),
        .Reset (Reset),
        .Clr   (Clr[0]),
        .En    (pos_en[0]),
        .Pos   (pos0)
    );

    seq_pos_counter #(.WIDTH(WIDTH)) u_pos1 (
        .CLK   (CLK),
        .Reset (Reset),
        .Clr   (Clr[1]),
        .En    (pos_en[1]),
        .Pos   (pos1)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            number_q <= SEED;
            done_q   <= '0;
            busy_q   <= 1'b0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            number_q <= number_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Req != 2'b00) state_d = ST_RUN;
            ST_RUN:  if (rem_q == (WIDTH+1)'(1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A tie goes to the requester that did not own the previous burst.
    always_comb begin
        win      = (Req == 2'b10) ? 1'b1 : (Req == 2'b01) ? 1'b0 : ~last_q;
        owner_d  = owner_q;
        last_d   = last_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        number_d = number_q;
        done_d   = '0;
        busy_d   = busy_q;
        rem_d    = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (Req != 2'b00) begin
                    owner_d = win;
                    grant_d = win ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    rem_d   = (WIDTH+1)'(burst_count(32'(win ? Len1 : Len0), WIDTH));
                end
            end
            ST_RUN: begin
                valid_d  = 1'b1;
                number_d = pos_w ^ SEED;
                rem_d    = rem_q - (WIDTH+1)'(1);
            end
            ST_DONE: begin
                valid_d = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
                done_d  = owner_q ? 2'b10 : 2'b01;
                last_d  = owner_q;
            end
            default: ;
        endcase
    end

    assign Grant  = grant_q;
    assign Valid  = valid_q;
    assign Number = number_q;
    assign Done   = done_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter: arbitration, resume, wrap, clear and reset scenarios.
module tb_seq_arbiter;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [1:0] Req;
    logic [3:0] Len0, Len1;
    logic [1:0] Clr;
    logic [1:0] Grant;
    logic       Valid;
    logic [3:0] Number;
    logic [1:0] Done;
    logic       Busy;

    int errors = 0;
    int checks = 0;

    // Sequence for SEED=5 indexed by saved position.
    logic [3:0] seq_tab [16] = '{4'd5, 4'd4, 4'd7, 4'd6, 4'd1, 4'd0, 4'd3, 4'd2,
                                 4'd13, 4'd12, 4'd15, 4'd14, 4'd9, 4'd8, 4'd11, 4'd10};
    int clr_pos [6] = '{0, 1, 2, 0, 1, 2};

    seq_arbiter #(.WIDTH(4), .SEED(4'b0101)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .Req    (Req),
        .Len0   (Len0),
        .Len1   (Len1),
        .Clr    (Clr),
        .Grant  (Grant),
        .Valid  (Valid),
        .Number (Number),
        .Done   (Done),
        .Busy   (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step();
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_number", 32'(Number), 32'd5);
        Reset = 1'b1;
    endtask

    task automatic grant(input logic [1:0] g);
        step();
        chk("grant", 32'(Grant), 32'(g));
        chk("grant_busy", 32'(Busy), 32'd1);
        chk("grant_valid", 32'(Valid), 32'd0);
    endtask

    task automatic burst(input logic [1:0] g, input int n, input int p0);
        for (int k = 0; k < n; k++) begin
            step();
            chk("run_valid", 32'(Valid), 32'd1);
            chk("run_number", 32'(Number), 32'(seq_tab[(p0 + k) % 16]));
            chk("run_grant", 32'(Grant), 32'(g));
            chk("run_done", 32'(Done), 32'd0);
        end
        step();
        chk("end_done", 32'(Done), 32'(g));
        chk("end_grant", 32'(Grant), 32'd0);
        chk("end_valid", 32'(Valid), 32'd0);
        chk("end_busy", 32'(Busy), 32'd0);
        chk("end_hold", 32'(Number), 32'(seq_tab[(p0 + n - 1) % 16]));
    endtask

    initial begin
        Reset = 1'b0; Req = 2'b00; Len0 = 4'd0; Len1 = 4'd0; Clr = 2'b00;
        step();
        do_reset();

        // Single requester, Len0=4.
        Req = 2'b01; Len0 = 4'd4;
        grant(2'b01);
        Req = 2'b00;
        burst(2'b01, 4, 0);
        step();
        chk("done_pulse_clear", 32'(Done), 32'd0);
        chk("idle_grant", 32'(Grant), 32'd0);

        // Tie after reset goes to requester 0, then requester 1, then 0 resumes.
        do_reset();
        Req = 2'b11; Len0 = 4'd2; Len1 = 4'd3;
        grant(2'b01);
        burst(2'b01, 2, 0);
        grant(2'b10);
        burst(2'b10, 3, 0);
        Req = 2'b01;
        grant(2'b01);
        Req = 2'b00;
        burst(2'b01, 2, 2);
        step();

        // Len0=0 means 16 values, then the next burst wraps to 5.
        do_reset();
        Req = 2'b01; Len0 = 4'd0;
        grant(2'b01);
        Req = 2'b00;
        burst(2'b01, 16, 0);
        step();
        Req = 2'b01; Len0 = 4'd1;
        grant(2'b01);
        Req = 2'b00;
        burst(2'b01, 1, 0);
        step();

        // Clear on the third RUN edge restarts the saved position.
        do_reset();
        Req = 2'b01; Len0 = 4'd6;
        grant(2'b01);
        Req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) Clr = 2'b01;
            step();
            Clr = 2'b00;
            chk("clr_valid", 32'(Valid), 32'd1);
            chk("clr_number", 32'(Number), 32'(seq_tab[clr_pos[k]]));
        end
        step();
        chk("clr_done", 32'(Done), 32'd1);
        step();

        // Clear coinciding with the grant edge: burst starts at position 0.
        Req = 2'b01; Clr = 2'b01; Len0 = 4'd1;
        grant(2'b01);
        Req = 2'b00; Clr = 2'b00;
        burst(2'b01, 1, 0);
        step();

        // Asynchronous reset mid-burst.
        do_reset();
        Req = 2'b01; Len0 = 4'd8;
        grant(2'b01);
        Req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_rst_number", 32'(Number), 32'(seq_tab[k]));
        end
        #2 Reset = 1'b0;
        #1;
        chk("async_grant", 32'(Grant), 32'd0);
        chk("async_valid", 32'(Valid), 32'd0);
        chk("async_number", 32'(Number), 32'd5);
        chk("async_busy", 32'(Busy), 32'd0);
        step();
        Reset = 1'b1;
        Req = 2'b01; Len0 = 4'd2;
        grant(2'b01);
        Req = 2'b00;
        burst(2'b01, 2, 0);
        step();

        // Req0 dropped after first value, Len0 changed after grant; Req1 pending.
        Req = 2'b01; Len0 = 4'd5; Len1 = 4'd1;
        grant(2'b01);
        Len0 = 4'd1;
        step();
        chk("drop_first", 32'(Number), 32'(seq_tab[2]));
        Req = 2'b10;
        burst(2'b01, 4, 3);
        grant(2'b10);
        Req = 2'b00;
        burst(2'b10, 1, 0);
        step();
        chk("final_idle", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
